alu_addr_unit: RTL and testbench
================================

ALU_ADDR_UNIT -- requirements
Module: alu_addr_unit

Interface
REQ-001 Parameter: W, 16, data/address width; only W=16 is supported.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operands and offsets valid this cycle.
REQ-005 Port: data1  input  16  ALU operand A.
REQ-006 Port: data2  input  16  ALU operand B.
REQ-007 Port: aluop  input  1  0 = ADD (A+B), 1 = SUB (A-B).
REQ-008 Port: pc  input  16  address of the instruction that owns the offsets.
REQ-009 Port: off5  input  5  signed JEQ branch offset.
REQ-010 Port: off11  input  11  signed JMP offset.
REQ-011 Port: out_valid  output  1  registered outputs hold a new result.
REQ-012 Port: result  output  16  ALU result.
REQ-013 Port: zero  output  1  high when result == 0x0000.
REQ-014 Port: jeq_addr  output  16  pc + sign-extended off5.
REQ-015 Port: jmp_addr  output  16  pc + sign-extended off11.
REQ-016 Port: carry  output  1  present only with ALU_FLAGS_EN; unsigned carry/no-borrow.
REQ-017 Port: overflow  output  1  present only with ALU_FLAGS_EN; signed overflow.

Function
REQ-018 ADD SHALL compute data1 + data2 modulo 2^16.
REQ-019 SUB SHALL compute data1 + ~data2 + 1 modulo 2^16.
REQ-020 zero SHALL be derived from the 16-bit wrapped result, not from a wider sum.
REQ-021 jeq_addr SHALL equal pc + {{11{off5[4]}}, off5} modulo 2^16; the base is pc itself, not pc+1.
REQ-022 jmp_addr SHALL equal pc + {{5{off11[10]}}, off11} modulo 2^16.
REQ-023 All outputs SHALL be registered with one-cycle latency: inputs sampled at edge N appear after edge N.
REQ-024 out_valid SHALL equal in_valid registered by one cycle.
REQ-025 With in_valid=0 at an edge, result, zero, jeq_addr, jmp_addr and flags SHALL hold their previous values.
REQ-026 Back-to-back in_valid=1 SHALL be accepted every cycle; there is no stall or backpressure.
REQ-027 ALU and both address adders SHALL evaluate in parallel from the same sampled inputs.

Reset
REQ-028 While reset=1 at a rising edge: out_valid=0, result=0x0000, zero=0, jeq_addr=0x0000, jmp_addr=0x0000, carry=0, overflow=0.
REQ-029 reset SHALL take priority over in_valid; an operation presented in the same cycle as reset is discarded.
REQ-030 The first valid operation after reset deassertion SHALL produce out_valid=1 one cycle later.

Configuration
REQ-031 Macro ALU_FLAGS_EN defined: carry and overflow ports SHALL exist and be registered alongside result.
- carry = carry-out of bit 15 of the adder (for SUB: 1 when data1 >= data2 unsigned).
- overflow = signed overflow of the selected operation.
REQ-032 Macro ALU_FLAGS_EN undefined: carry and overflow ports and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 aluop=0, data1=0x0003, data2=0x0004, in_valid=1 -> next cycle result=0x0007, zero=0, out_valid=1.
REQ-034 aluop=1, data1=0x1234, data2=0x1234 -> result=0x0000, zero=1, carry=1 (flags build).
REQ-035 aluop=0, data1=0xFFFF, data2=0x0001 -> result=0x0000, zero=1, carry=1, overflow=0; aluop=1, 0x8000-0x0001 -> result=0x7FFF, overflow=1.
REQ-036 pc=0x0010, off5=0x1F, off11=0x400 -> jeq_addr=0x000F, jmp_addr=0xFC10; pc=0xFFFF, off5=0x01 -> jeq_addr=0x0000.
REQ-037 reset=1 asserted while in_valid=1 with nonzero operands -> next cycle all outputs 0 and out_valid=0; in_valid=0 after a valid op -> outputs hold and out_valid=0.

Source files
------------

// File: rtl/alu_addr_unit_if.sv
// Operand/offset bus and registered result bus of alu_addr_unit.
// carry/overflow exist only when ALU_FLAGS_EN is defined.
interface alu_addr_unit_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic         aluop;
  logic [W-1:0] pc;
  logic [4:0]   off5;
  logic [10:0]  off11;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic [W-1:0] jeq_addr;
  logic [W-1:0] jmp_addr;
`ifdef ALU_FLAGS_EN
  logic         carry;
  logic         overflow;
`endif

  // Handshake: in_valid qualifies inputs for exactly one edge; there is no ready.
  // out_valid is in_valid delayed one cycle; result fields hold when it is low.
  modport master (
    output in_valid, data1, data2, aluop, pc, off5, off11,
`ifdef ALU_FLAGS_EN
    input  carry, overflow,
`endif
    input  out_valid, result, zero, jeq_addr, jmp_addr
  );

  modport slave (
    input  in_valid, data1, data2, aluop, pc, off5, off11,
`ifdef ALU_FLAGS_EN
    output carry, overflow,
`endif
    output out_valid, result, zero, jeq_addr, jmp_addr
  );
endinterface

// File: rtl/alu_addr_unit.sv
// Single-cycle ADD/SUB ALU plus JEQ/JMP branch-target adders, all registered.
// Optional macro ALU_FLAGS_EN adds registered carry and overflow outputs.
module alu_addr_unit #(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_addr_unit_if.slave bus
);
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q,    result_d;
  logic         zero_q,      zero_d;
  logic [W-1:0] jeq_addr_q,  jeq_addr_d;
  logic [W-1:0] jmp_addr_q,  jmp_addr_d;

  logic [W-1:0] operand_b;
  logic [W-1:0] alu_res;
  logic [W-1:0] jeq_sum;
  logic [W-1:0] jmp_sum;

`ifdef ALU_FLAGS_EN
  logic         carry_q,     carry_d;
  logic         overflow_q,  overflow_d;
  logic [W:0]   sum_full;
  logic         carry_c;
  logic         overflow_c;
`endif

  // SUB reuses the adder: A + ~B + 1, with the +1 fed in as carry-in.
  always_comb begin
    operand_b = bus.aluop ? ~bus.data2 : bus.data2;
`ifdef ALU_FLAGS_EN
    sum_full   = {1'b0, bus.data1} + {1'b0, operand_b} + {{W{1'b0}}, bus.aluop};
    alu_res    = sum_full[W-1:0];
    carry_c    = sum_full[W];
    overflow_c = (bus.data1[W-1] == operand_b[W-1]) && (alu_res[W-1] != bus.data1[W-1]);
`else
    alu_res    = bus.data1 + operand_b + {{(W-1){1'b0}}, bus.aluop};
`endif
  end

  // Branch targets are relative to the owning instruction's own pc.
  always_comb begin
    jeq_sum = bus.pc + {{(W-5){bus.off5[4]}}, bus.off5};
    jmp_sum = bus.pc + {{(W-11){bus.off11[10]}}, bus.off11};
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    result_d    = result_q;
    zero_d      = zero_q;
    jeq_addr_d  = jeq_addr_q;
    jmp_addr_d  = jmp_addr_q;
`ifdef ALU_FLAGS_EN
    carry_d     = carry_q;
    overflow_d  = overflow_q;
`endif
    if (bus.in_valid) begin
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      jeq_addr_d = jeq_sum;
      jmp_addr_d = jmp_sum;
`ifdef ALU_FLAGS_EN
      carry_d    = carry_c;
      overflow_d = overflow_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      jeq_addr_q  <= '0;
      jmp_addr_q  <= '0;
`ifdef ALU_FLAGS_EN
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      jeq_addr_q  <= jeq_addr_d;
      jmp_addr_q  <= jmp_addr_d;
`ifdef ALU_FLAGS_EN
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.jeq_addr  = jeq_addr_q;
  assign bus.jmp_addr  = jmp_addr_q;
`ifdef ALU_FLAGS_EN
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
`endif
endmodule

// File: tb/tb_alu_addr_unit.sv
// Directed + random bench for alu_addr_unit with an expected-result queue.
// Flag checks are included when ALU_FLAGS_EN is defined.
module tb_alu_addr_unit;
  localparam int W = 16;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic [15:0] jeq;
    logic [15:0] jmp;
    logic        carry;
    logic        overflow;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  exp_t held;
  int   n_vec = 0;
  int   n_err = 0;

  alu_addr_unit_if #(.W(W)) bus ();

  alu_addr_unit #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] p, input logic [4:0] o5, input logic [10:0] o11);
    exp_t e;
    int   s5;
    int   s11;
    int   ua;
    int   ub;
    ua = int'(a);
    ub = int'(b);
    e.result = op ? 16'(ua - ub) : 16'(ua + ub);
    e.zero   = (e.result == 16'h0000);
    e.carry  = op ? (ua >= ub) : ((ua + ub) > 65535);
    if (op) e.overflow = (a[15] != b[15]) && (e.result[15] != a[15]);
    else    e.overflow = (a[15] == b[15]) && (e.result[15] != a[15]);
    s5  = o5[4]   ? int'(o5) - 32     : int'(o5);
    s11 = o11[10] ? int'(o11) - 2048  : int'(o11);
    e.jeq = 16'(int'(p) + s5);
    e.jmp = 16'(int'(p) + s11);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic op,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                      input logic [4:0] o5, input logic [10:0] o11);
    logic ev;
    reset        = rst;
    bus.in_valid = v;
    bus.aluop    = op;
    bus.data1    = a;
    bus.data2    = b;
    bus.pc       = p;
    bus.off5     = o5;
    bus.off11    = o11;
    ev = v && !rst;
    if (ev) exp_q.push_back(model(op, a, b, p, o5, o11));
    @(posedge clk);
    #1;
    chk("out_valid", 16'(bus.out_valid), 16'(ev));
    if (rst) begin
      held = '0;
      exp_q.delete();
    end else if (ev) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        held = exp_q.pop_front();
      end
    end
    chk("result",   bus.result,       held.result);
    chk("zero",     16'(bus.zero),    16'(held.zero));
    chk("jeq_addr", bus.jeq_addr,     held.jeq);
    chk("jmp_addr", bus.jmp_addr,     held.jmp);
`ifdef ALU_FLAGS_EN
    chk("carry",    16'(bus.carry),   16'(held.carry));
    chk("overflow", 16'(bus.overflow),16'(held.overflow));
`endif
  endtask

  initial begin
    logic        r_v;
    logic        r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_p;
    held = '0;
    // reset held while a valid operation is presented: must be discarded
    step(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 5'h05, 11'h055);
    step(1'b1, 1'b1, 1'b1, 16'hABCD, 16'h0001, 16'h4444, 5'h1F, 11'h7FF);
    // first op after reset, then directed corner cases back to back
    step(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0004, 16'h0100, 5'h00, 11'h000);
    step(1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h0010, 5'h1F, 11'h400);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 5'h01, 11'h001);
    step(1'b0, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h0000, 5'h10, 11'h3FF);
    step(1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'h0F, 11'h7FF);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFF0, 5'h10, 11'h400);
    // idle cycles: outputs hold with different operands on the bus
    step(1'b0, 1'b0, 1'b0, 16'h5555, 16'hAAAA, 16'h1234, 5'h07, 11'h123);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 5'h00, 11'h000);
    // mid-run reset with valid operands, then recovery
    step(1'b1, 1'b1, 1'b0, 16'h0F0F, 16'h0101, 16'h2000, 5'h03, 11'h010);
    step(1'b0, 1'b1, 1'b0, 16'h00FF, 16'hFF01, 16'h0020, 5'h11, 11'h600);
    for (int i = 0; i < 40; i++) begin
      r_v  = ($urandom_range(0, 3) != 0);
      r_op = 1'($urandom_range(0, 1));
      r_a  = 16'($urandom_range(0, 65535));
      r_b  = ($urandom_range(0, 7) == 0) ? r_a : 16'($urandom_range(0, 65535));
      r_p  = 16'($urandom_range(0, 65535));
      step(1'b0, r_v, r_op, r_a, r_b, r_p, 5'($urandom_range(0, 31)), 11'($urandom_range(0, 2047)));
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'h00, 11'h000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
